// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg : shared owner type and default limits for the bus arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bus_arbiter_pkg;

   typedef enum logic {
      OWNER_CORE = 1'b0,
      OWNER_DMA  = 1'b1
   } owner_e;

   localparam int DMA_MAX_BURST_DEF = 8;
   localparam int CORE_MIN_GAP_DEF  = 2;

endpackage

`default_nettype wire

// File: rtl/bus_mux2.sv
// ----------------------------------------------------------------------------
// bus_mux2 : two-master select of address, write data and {read,write} strobes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_mux2
   import bus_arbiter_pkg::*;
(
   input  owner_e      owner,
   input  logic [15:0] core_address,
   input  logic [7:0]  core_data_out,
   input  logic [1:0]  core_strobe,
   input  logic [15:0] dma_address,
   input  logic [7:0]  dma_write_data,
   input  logic [1:0]  dma_strobe,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_data_out,
   output logic [1:0]  mem_strobe
);

   always_comb begin
      mem_address  = core_address;
      mem_data_out = core_data_out;
      mem_strobe   = core_strobe;
      if (owner == OWNER_DMA) begin
         mem_address  = dma_address;
         mem_data_out = dma_write_data;
         mem_strobe   = dma_strobe;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter : shares the memory bus between the 6502 core and a DMA requester
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int DMA_MAX_BURST = DMA_MAX_BURST_DEF,
   parameter int CORE_MIN_GAP  = CORE_MIN_GAP_DEF
) (
   input  logic        ph1,
   input  logic        reset,
   input  logic [15:0] core_address,
   input  logic [7:0]  core_data_out,
   input  logic        core_read_en,
   output logic [7:0]  core_data_in,
   output logic        core_stall,
   input  logic        dma_req,
   input  logic [15:0] dma_address,
   input  logic [7:0]  dma_write_data,
   input  logic        dma_we,
   output logic        dma_gnt,
   output logic        dma_ack,
   output logic [7:0]  dma_read_data,
   output logic [15:0] mem_address,
   output logic [7:0]  mem_data_out,
   output logic        mem_read_en,
   output logic        mem_write_en,
   input  logic [7:0]  mem_data_in
);

   localparam int BW = $clog2(DMA_MAX_BURST + 1);
   localparam int GW = $clog2(CORE_MIN_GAP + 1);

   owner_e          owner_q, owner_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d, burst_inc;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   owner_e          mux_owner;
   logic [1:0]      core_strobe, dma_strobe, mem_strobe;

   always_comb begin
      owner_d     = owner_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      burst_inc   = burst_cnt_q + BW'(1);
      if (owner_q == OWNER_CORE) begin
         if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GW'(1);
         end
         // Only a read cycle may hand over, so RMW write-backs stay atomic.
         if (dma_req && (gap_cnt_q == '0) && core_read_en) begin
            owner_d     = OWNER_DMA;
            burst_cnt_d = '0;
         end
      end else begin
         if (dma_req) begin
            burst_cnt_d = burst_inc;
            if (burst_inc == BW'(DMA_MAX_BURST)) begin
               owner_d   = OWNER_CORE;
               gap_cnt_d = GW'(CORE_MIN_GAP);
            end
         end else begin
            owner_d   = OWNER_CORE;
            gap_cnt_d = GW'(CORE_MIN_GAP);
         end
      end
   end

   always_ff @(posedge ph1) begin
      if (!reset) begin
         owner_q     <= OWNER_CORE;
         burst_cnt_q <= '0;
         gap_cnt_q   <= '0;
      end else begin
         owner_q     <= owner_d;
         burst_cnt_q <= burst_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign core_stall    = (owner_q == OWNER_DMA);
   assign dma_gnt       = (owner_q == OWNER_DMA);
   assign dma_ack       = dma_gnt & dma_req & reset;
   assign core_data_in  = mem_data_in;
   assign dma_read_data = mem_data_in;

   // While reset is held the bus is handed straight back to the core.
   assign mux_owner   = reset ? owner_q : OWNER_CORE;
   assign core_strobe = {core_read_en, ~core_read_en};
   assign dma_strobe  = {dma_req & ~dma_we, dma_req & dma_we};

   bus_mux2 u_mux (
      .owner          (mux_owner),
      .core_address   (core_address),
      .core_data_out  (core_data_out),
      .core_strobe    (core_strobe),
      .dma_address    (dma_address),
      .dma_write_data (dma_write_data),
      .dma_strobe     (dma_strobe),
      .mem_address    (mem_address),
      .mem_data_out   (mem_data_out),
      .mem_strobe     (mem_strobe)
   );

   assign mem_read_en  = mem_strobe[1];
   assign mem_write_en = mem_strobe[0] & reset;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter : vector table, burst-limit sequence and random model check
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_bus_arbiter;
   import bus_arbiter_pkg::*;

   localparam int MAXB = DMA_MAX_BURST_DEF;
   localparam int GAP  = CORE_MIN_GAP_DEF;

   logic        ph1 = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] core_address = 16'hFFFC;
   logic [7:0]  core_data_out = 8'h77;
   logic        core_read_en = 1'b1;
   logic [7:0]  core_data_in;
   logic        core_stall;
   logic        dma_req = 1'b1;
   logic [15:0] dma_address = 16'h0400;
   logic [7:0]  dma_write_data = 8'h3C;
   logic        dma_we = 1'b0;
   logic        dma_gnt;
   logic        dma_ack;
   logic [7:0]  dma_read_data;
   logic [15:0] mem_address;
   logic [7:0]  mem_data_out;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [7:0]  mem_data_in = 8'hA5;

   int checks = 0;
   int errors = 0;

   bus_arbiter dut (
      .ph1            (ph1),
      .reset          (reset),
      .core_address   (core_address),
      .core_data_out  (core_data_out),
      .core_read_en   (core_read_en),
      .core_data_in   (core_data_in),
      .core_stall     (core_stall),
      .dma_req        (dma_req),
      .dma_address    (dma_address),
      .dma_write_data (dma_write_data),
      .dma_we         (dma_we),
      .dma_gnt        (dma_gnt),
      .dma_ack        (dma_ack),
      .dma_read_data  (dma_read_data),
      .mem_address    (mem_address),
      .mem_data_out   (mem_data_out),
      .mem_read_en    (mem_read_en),
      .mem_write_en   (mem_write_en),
      .mem_data_in    (mem_data_in)
   );

   always #5 ph1 = ~ph1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic rst, cre, req, we;
      logic gnt, ack, rd, wr;
   } vec_t;

   vec_t tbl[15];

   // Reference model: whether DMA holds the bus, acks taken in this grant,
   // and core cycles elapsed since DMA last released the bus.
   bit m_dma;
   int m_acks;
   int m_since;

   initial begin
      logic        e_gnt, e_ack, e_rd, e_wr, sel_dma;
      logic [15:0] e_addr;
      logic [7:0]  e_wd;

      //         rst  cre  req  we   gnt  ack  rd   wr
      tbl[0]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[3]  = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1};
      tbl[4]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[5]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0};
      tbl[6]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1};
      tbl[7]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,1'b0};
      tbl[8]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0};
      tbl[9]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[10] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[11] = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0};
      tbl[12] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1};
      tbl[13] = '{1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0};
      tbl[14] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0};

      for (int i = 0; i < 15; i++) begin
         @(posedge ph1); #1;
         reset          = tbl[i].rst;
         core_read_en   = tbl[i].cre;
         dma_req        = tbl[i].req;
         dma_we         = tbl[i].we;
         core_address   = (i < 3) ? 16'hFFFC : 16'h0200;
         dma_address    = 16'h0400;
         core_data_out  = 8'h77;
         dma_write_data = 8'h3C;
         mem_data_in    = 8'hA5;
         #1;
         e_addr = (tbl[i].gnt && tbl[i].rst) ? 16'h0400 : core_address;
         chk($sformatf("vec%0d gnt", i), dma_gnt, tbl[i].gnt);
         chk($sformatf("vec%0d stall", i), core_stall, tbl[i].gnt);
         chk($sformatf("vec%0d ack", i), dma_ack, tbl[i].ack);
         chk($sformatf("vec%0d rd", i), mem_read_en, tbl[i].rd);
         chk($sformatf("vec%0d wr", i), mem_write_en, tbl[i].wr);
         chk($sformatf("vec%0d addr", i), mem_address, e_addr);
         if (tbl[i].ack)
            chk($sformatf("vec%0d dma_rdata", i), dma_read_data, 8'hA5);
      end

      // Continuous request: MAXB acks, then GAP+1 core cycles, repeating.
      @(posedge ph1); #1;
      reset = 1'b0; dma_req = 1'b1; core_read_en = 1'b1; dma_we = 1'b0;
      for (int t = 0; t < 34; t++) begin
         @(posedge ph1); #1;
         reset = 1'b1;
         #1;
         e_ack = ((t % (MAXB + GAP + 1)) >= 1) && ((t % (MAXB + GAP + 1)) <= MAXB);
         chk($sformatf("burst t%0d ack", t), dma_ack, e_ack);
         chk($sformatf("burst t%0d stall", t), core_stall, e_ack);
      end

      @(posedge ph1); #1;
      reset = 1'b0;
      m_dma = 1'b0; m_acks = 0; m_since = GAP;

      for (int c = 0; c < 500; c++) begin
         @(posedge ph1); #1;
         reset          = ($urandom_range(0, 59) != 0);
         core_read_en   = ($urandom_range(0, 3) != 0);
         dma_req        = ($urandom_range(0, 7) != 0);
         dma_we         = $urandom_range(0, 1);
         core_address   = 16'($urandom);
         dma_address    = 16'($urandom);
         core_data_out  = 8'($urandom);
         dma_write_data = 8'($urandom);
         mem_data_in    = 8'($urandom);
         #1;
         sel_dma = m_dma && reset;
         e_gnt   = m_dma;
         e_ack   = m_dma && dma_req && reset;
         e_rd    = sel_dma ? (dma_req && !dma_we) : core_read_en;
         e_wr    = reset && (sel_dma ? (dma_req && dma_we) : !core_read_en);
         e_addr  = sel_dma ? dma_address : core_address;
         e_wd    = sel_dma ? dma_write_data : core_data_out;
         chk($sformatf("rnd%0d gnt", c), dma_gnt, e_gnt);
         chk($sformatf("rnd%0d stall", c), core_stall, e_gnt);
         chk($sformatf("rnd%0d ack", c), dma_ack, e_ack);
         chk($sformatf("rnd%0d rd", c), mem_read_en, e_rd);
         chk($sformatf("rnd%0d wr", c), mem_write_en, e_wr);
         chk($sformatf("rnd%0d addr", c), mem_address, e_addr);
         chk($sformatf("rnd%0d wdata", c), mem_data_out, e_wd);
         chk($sformatf("rnd%0d core_rdata", c), core_data_in, mem_data_in);
         chk($sformatf("rnd%0d dma_rdata", c), dma_read_data, mem_data_in);

         if (!reset) begin
            m_dma = 1'b0; m_acks = 0; m_since = GAP;
         end else if (m_dma) begin
            if (dma_req) m_acks++;
            if (!dma_req || m_acks == MAXB) begin
               m_dma = 1'b0; m_since = 0;
            end
         end else if (dma_req && core_read_en && m_since >= GAP) begin
            m_dma = 1'b1; m_acks = 0;
         end else if (m_since < GAP) begin
            m_since++;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single external memory bus between the 6502 core and one cycle-stealing DMA requester (video/IO refresh).
- Sits between the core's address/data_out/read_en pins and the memory interface.
- Stalls the core RDY-style while DMA owns the bus.
- Bounds DMA bursts so the core is never starved.

Parameters:
- DMA_MAX_BURST, 8: maximum consecutive DMA transfers per grant (>=1).
- CORE_MIN_GAP, 2: minimum core-owned cycles after a DMA grant ends before DMA may be re-granted (>=1).

Ports:
- ph1  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- core_address  in  16  core bus address.
- core_data_out  in  8  core write data.
- core_read_en  in  1  1 = core read cycle, 0 = core write cycle.
- core_data_in  out  8  read data to core; equals mem_data_in.
- core_stall  out  1  1 = core must freeze and hold its outputs.
- dma_req  in  1  DMA wants a transfer this cycle (level).
- dma_address  in  16  DMA address.
- dma_write_data  in  8  DMA write data.
- dma_we  in  1  1 = DMA write, 0 = DMA read.
- dma_gnt  out  1  DMA owns the bus.
- dma_ack  out  1  DMA transfer completes this cycle.
- dma_read_data  out  8  equals mem_data_in.
- mem_address  out  16  muxed address.
- mem_data_out  out  8  muxed write data.
- mem_read_en  out  1  memory read strobe.
- mem_write_en  out  1  memory write strobe.
- mem_data_in  in  8  memory read data.

Behaviour:
- Registered state: CORE, DMA. Counters: burst_cnt, width clog2(DMA_MAX_BURST+1); gap_cnt, width clog2(CORE_MIN_GAP+1).
- Reset (reset==0 at edge):
  - State becomes CORE; burst_cnt=0; gap_cnt=0.
  - Outputs: core_stall=0, dma_gnt=0, dma_ack=0. The mux selects the core.
  - mem_write_en is forced to 0 combinationally while reset==0.
  - Reset mid-burst abandons the burst. No ack is issued in the cycle after the edge.
- CORE state:
  - Mux: mem_address=core_address, mem_data_out=core_data_out, mem_read_en=core_read_en, mem_write_en=~core_read_en.
  - core_stall=0, dma_gnt=0, dma_ack=0.
  - If gap_cnt!=0, decrement it.
  - Go to DMA next cycle when dma_req=1, gap_cnt==0, and core_read_en=1. The current core read still completes this cycle.
  - Core write cycles are never followed by a grant, so read-modify-write write-backs are never split (6502 RDY semantics).
  - On entry to DMA, load burst_cnt=0.
- DMA state:
  - core_stall=1, dma_gnt=1. Mux selects DMA: mem_address=dma_address, mem_data_out=dma_write_data.
  - If dma_req=1: mem_read_en=~dma_we, mem_write_en=dma_we, dma_ack=1 (combinational, same cycle), burst_cnt++.
  - If dma_req=0: mem_read_en=0, mem_write_en=0, dma_ack=0.
  - Exit to CORE next cycle if dma_req=0, or if this transfer makes burst_cnt reach DMA_MAX_BURST. On exit, load gap_cnt=CORE_MIN_GAP.
  - Exit due to dma_req dropping costs one idle bus cycle with no strobes.
- Latency: dma_req rising in a CORE read cycle with gap_cnt==0 gives the first dma_ack exactly one cycle later.
- Maximum DMA occupancy: DMA_MAX_BURST consecutive acks, then at least CORE_MIN_GAP unstalled core cycles.
- Invariants:
  - dma_ack implies dma_gnt; dma_gnt equals core_stall.
  - mem_read_en and mem_write_en are never both 1.
- Read data: core_data_in and dma_read_data both carry mem_data_in unconditionally. Consumers qualify with ~core_stall or dma_ack.

Decomposition:
- Shared package: owner state typedef (OWNER_CORE, OWNER_DMA) and default constants DMA_MAX_BURST_DEF=8, CORE_MIN_GAP_DEF=2. Reused by the testbench and the future multi-master variant.
- One natural sub-module: bus_mux2, a combinational 16+8+2-bit master select (address, write data, strobes) driven by owner.
- Counters and FSM stay in bus_arbiter.

Test Plan:
- Reset hold 3 cycles with dma_req=1 -> core_stall=0, dma_gnt=0, mem_write_en=0 throughout; mem_address tracks core_address=16'hFFFC.
- Core read at 16'h0200, dma_req=1, dma_we=0, dma_address=16'h0400 -> next cycle: dma_gnt=1, core_stall=1, mem_address=16'h0400, mem_read_en=1, dma_ack=1; dma_read_data=mem_data_in=8'hA5.
- Core write cycle (core_read_en=0) with dma_req=1 -> no grant that cycle; grant only after the next core read cycle.
- dma_req held high continuously -> exactly 8 acks, then 2 cycles of core_stall=0, then re-grant; repeats with period 11 cycles (1 grant-request cycle included).
- dma_req dropped after 3 acks -> 4th DMA cycle has no strobes and dma_ack=0; CORE next cycle; gap_cnt=2; dma_req re-raised is ignored for 2 cycles.
- reset asserted during DMA write burst (dma_we=1) -> mem_write_en=0 immediately; state CORE, core_stall=0 after the edge; no further dma_ack.
